// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx: captures an I2S stream into left/right sample pairs and
// queues them in a small first-word-fall-through FIFO with a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not aligned to a frame; waiting for lrclk 1->0 with en=1
// LEFT  | collecting the left slot; closes on lrclk 0->1
// RIGHT | collecting the right slot; closes on lrclk 1->0 and pushes
module i2s_sample_rx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        i2s_bclk,
    input  logic                        i2s_lrclk,
    input  logic                        i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0]     sample_left,
    output logic [SAMPLE_WIDTH-1:0]     sample_right,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        frame_err
);

    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PW + 1;
    localparam int CW      = $clog2(SLOT_WIDTH);
    localparam int PAIR_W  = 2 * SAMPLE_WIDTH;
    localparam logic [SAMPLE_WIDTH-1:0] MSB_ONE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    // ---------------- input synchronisers ----------------
    logic [1:0] bclk_sync, lrclk_sync, sdata_sync;
    logic       bclk_prev;
    logic       bre, lr, sd;

    // Equal-depth 2-FF synchronisers keep bclk, lrclk and sdata aligned to each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            sdata_sync <= '0;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[0], i2s_bclk};
            lrclk_sync <= {lrclk_sync[0], i2s_lrclk};
            sdata_sync <= {sdata_sync[0], i2s_sdata};
            bclk_prev  <= bclk_sync[1];
        end
    end

    assign bre = bclk_sync[1] & ~bclk_prev;
    assign lr  = lrclk_sync[1];
    assign sd  = sdata_sync[1];

    // ---------------- slot deserialiser FSM ----------------
    state_t                  state, state_next;
    logic [CW-1:0]           cnt, cnt_next;
    logic [SAMPLE_WIDTH-1:0] shift_word, shift_next;
    logic [SAMPLE_WIDTH-1:0] left_word, left_next;
    logic [SAMPLE_WIDTH-1:0] slot_word;
    logic [SAMPLE_WIDTH-1:0] bit_sel;
    logic                    lr_prev, lr_prev_next;
    logic                    push, err;

    // Bit n lands at position SAMPLE_WIDTH-1-n; the shift yields zero for n beyond the kept width.
    assign bit_sel   = MSB_ONE >> cnt;
    assign slot_word = sd ? (shift_word | bit_sel) : shift_word;

    // State and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_word <= '0;
            left_word  <= '0;
            lr_prev    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            shift_word <= shift_next;
            left_word  <= left_next;
            lr_prev    <= lr_prev_next;
            frame_err  <= err;
        end
    end

    // Next-state logic; all slot work is gated by a bclk rising edge.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        shift_next   = shift_word;
        left_next    = left_word;
        lr_prev_next = lr_prev;
        push         = 1'b0;
        err          = 1'b0;

        if (bre) begin
            lr_prev_next = lr;
        end

        if (!en) begin
            state_next = IDLE;
        end else if (bre) begin
            case (state)
                IDLE: begin
                    if (lr_prev && !lr) begin
                        state_next = LEFT;
                        cnt_next   = '0;
                        shift_next = '0;
                    end
                end
                LEFT, RIGHT: begin
                    if (lr != lr_prev) begin
                        // this bit is the last one of the closing slot
                        cnt_next   = '0;
                        shift_next = '0;
                        if (state == LEFT) begin
                            left_next  = slot_word;
                            state_next = RIGHT;
                        end else begin
                            push       = 1'b1;
                            state_next = LEFT;
                        end
                    end else if (cnt == CW'(SLOT_WIDTH - 1)) begin
                        err        = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = cnt + 1'b1;
                        shift_next = slot_word;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- sample-pair FIFO ----------------
    logic [PAIR_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic [PAIR_W-1:0]  head, hold;
    logic               full, do_pop, do_push;

    assign sample_valid = (count != '0);
    assign full         = (count == LEVEL_W'(FIFO_DEPTH));
    assign do_pop       = sample_valid & sample_ready;
    // When full, a push is only taken if the head leaves in the same cycle.
    assign do_push      = push & (~full | do_pop);
    assign head         = mem[rd_ptr];

    // Storage array; read is combinational so the popped word is the pre-edge head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {left_word, slot_word};
        end
    end

    // Pointers, level, sticky overflow and the last-popped hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            hold     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= head;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs show the head while valid, otherwise the last word handed out.
    assign sample_left  = sample_valid ? head[PAIR_W-1:SAMPLE_WIDTH] : hold[PAIR_W-1:SAMPLE_WIDTH];
    assign sample_right = sample_valid ? head[SAMPLE_WIDTH-1:0]      : hold[SAMPLE_WIDTH-1:0];
    assign fifo_level   = count;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb_i2s_sample_rx: drives I2S frames built from a slot-level description and
// checks the FIFO output against a capacity-limited queue of expected pairs.
module tb_i2s_sample_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_left, sample_right;
    logic        sample_valid, overflow, frame_err;
    logic [2:0]  fifo_level;

    i2s_sample_rx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // stream under construction: channel and data bit per bclk period
    logic        ch_q[$];
    logic        bit_q[$];
    logic        push_q[$];
    logic        pulse_q[$];
    logic [31:0] pend_q[$];
    // model of the FIFO contents
    logic [31:0] model_q[$];
    logic        model_ovf = 1'b0;
    logic        locked = 1'b0;
    logic        mon_en = 1'b0;
    int          err_seen = 0;
    int          exp_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] rand_val(input int len);
        if (len >= 16) return 16'($urandom);
        return 16'($urandom_range(0, (1 << len) - 1));
    endfunction

    // Captured word: MSB-aligned, truncated or zero-padded to 16 bits.
    function automatic logic [15:0] cap_word(input logic [15:0] val, input int len);
        if (len >= 16) return val;
        return 16'(val << (16 - len));
    endfunction

    task automatic add_slot(input logic ch, input logic [15:0] val, input int len);
        logic b;
        for (int i = 0; i < len; i++) begin
            if (len >= 16) b = (i < 16) ? val[15-i] : 1'($urandom);
            else           b = val[len-1-i];
            ch_q.push_back(ch);
            bit_q.push_back(b);
            push_q.push_back(1'b0);
            pulse_q.push_back(1'b0);
        end
    endtask

    task automatic add_preamble(input int len);
        add_slot(1'b1, 16'($urandom), len);
        locked = en;
    endtask

    task automatic add_frame(input logic [15:0] l, input int ll, input logic [15:0] r, input int rl,
                             input bit pulse = 1'b0);
        add_slot(1'b0, l, ll);
        add_slot(1'b1, r, rl);
        if (locked && ll <= 32 && rl <= 32) begin
            push_q[push_q.size()-1]   = 1'b1;
            pulse_q[pulse_q.size()-1] = pulse;
            pend_q.push_back({cap_word(l, ll), cap_word(r, rl)});
        end
        if (ll > 32 || rl > 32) exp_err++;
    endtask

    task automatic model_push();
        logic [31:0] p;
        p = pend_q.pop_front();
        if (model_q.size() == 4) model_ovf = 1'b1;
        else                     model_q.push_back(p);
    endtask

    // Each period: lrclk leads the data by one bit, bclk low 4 clk then high 4 clk.
    task automatic play(input logic final_lr);
        for (int j = 0; j < bit_q.size(); j++) begin
            @(posedge clk); #1;
            i2s_bclk  = 1'b0;
            i2s_sdata = bit_q[j];
            i2s_lrclk = (j + 1 < ch_q.size()) ? ch_q[j+1] : final_lr;
            repeat (4) @(posedge clk);
            #1;
            i2s_bclk = 1'b1;
            // rising edge is seen after two sync stages; the slot action lands on the third edge
            @(posedge clk);
            @(posedge clk); #1;
            if (pulse_q[j]) sample_ready = 1'b1;
            @(posedge clk); #1;
            if (pulse_q[j]) sample_ready = 1'b0;
            if (push_q[j]) model_push();
        end
        ch_q.delete();
        bit_q.delete();
        push_q.delete();
        pulse_q.delete();
    endtask

    task automatic drain(input int cycles);
        @(posedge clk); #1;
        sample_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        sample_ready = 1'b0;
    endtask

    task automatic do_reset(input bit chk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        if (chk) begin
            check_eq("rst_left",     32'(sample_left),  32'h0);
            check_eq("rst_right",    32'(sample_right), 32'h0);
            check_eq("rst_valid",    32'(sample_valid), 32'h0);
            check_eq("rst_level",    32'(fifo_level),   32'h0);
            check_eq("rst_overflow", 32'(overflow),     32'h0);
            check_eq("rst_frame_err",32'(frame_err),    32'h0);
        end
        rst = 1'b0;
        model_q.delete();
        pend_q.delete();
        model_ovf = 1'b0;
        locked = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    // Scoreboard: FIFO head, level and flags against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_err) err_seen++;
            check_eq("valid",    32'(sample_valid), 32'(model_q.size() != 0));
            check_eq("level",    32'(fifo_level),   32'(model_q.size()));
            check_eq("overflow", 32'(overflow),     32'(model_ovf));
            if (model_q.size() != 0) begin
                check_eq("head_left",  32'(sample_left),  32'(model_q[0][31:16]));
                check_eq("head_right", 32'(sample_right), 32'(model_q[0][15:0]));
                if (sample_ready) void'(model_q.pop_front());
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l3[5];
        logic [15:0] lv, rv;
        int ll, rl;

        repeat (3) @(posedge clk);
        do_reset(1'b1);

        // 1: partial frame at start is dropped, first full frame captured
        add_slot(1'b0, rand_val(10), 10);
        add_preamble(32);
        add_frame(16'h1234, 32, 16'hABCD, 32);
        play(1'b0);
        check_eq("t1_valid", 32'(sample_valid), 32'h1);
        check_eq("t1_left",  32'(sample_left),  32'h1234);
        check_eq("t1_right", 32'(sample_right), 32'hABCD);
        check_eq("t1_level", 32'(fifo_level),   32'h1);
        drain(4);

        // 2: 16-bit slots exact, 12-bit slots zero-padded
        add_frame(16'h8001, 16, 16'h7FFE, 16);
        add_frame(16'h0ABC, 12, rand_val(12), 12);
        play(1'b0);
        check_eq("t2_left16",  32'(sample_left),  32'h8001);
        check_eq("t2_right16", 32'(sample_right), 32'h7FFE);
        drain(1);
        check_eq("t2_left12",  32'(sample_left),  32'hABC0);
        drain(4);

        // 3: five frames with no consumer -> four kept, overflow set
        for (int i = 0; i < 5; i++) begin
            l3[i] = rand_val(16);
            add_frame(l3[i], 32, rand_val(16), 32);
        end
        play(1'b0);
        check_eq("t3_level",    32'(fifo_level), 32'h4);
        check_eq("t3_overflow", 32'(overflow),   32'h1);
        drain(8);
        check_eq("t3_empty",     32'(sample_valid), 32'h0);
        check_eq("t3_hold_left", 32'(sample_left),  32'(l3[3]));

        // 4: push and pop in the same cycle while full
        do_reset(1'b0);
        add_preamble(32);
        for (int i = 0; i < 4; i++) add_frame(rand_val(16), 32, rand_val(16), 32);
        play(1'b0);
        check_eq("t4_full_level", 32'(fifo_level), 32'h4);
        add_frame(16'h5A5A, 32, 16'hC3C3, 32, 1'b1);
        play(1'b0);
        check_eq("t4_level",    32'(fifo_level), 32'h4);
        check_eq("t4_overflow", 32'(overflow),   32'h0);
        drain(8);

        // 5: over-long left slot -> one frame_err, resync, next frame captured
        err_seen = 0;
        exp_err = 0;
        add_frame(rand_val(16), 40, rand_val(16), 32);
        add_frame(16'h0F0F, 32, 16'hF00F, 32);
        add_frame(16'h1111, 24, 16'h2222, 32);
        play(1'b0);
        check_eq("t5_err_count", 32'(err_seen),   32'(exp_err));
        check_eq("t5_level",     32'(fifo_level), 32'h2);
        drain(6);

        // random frames with a random consumer
        for (int k = 0; k < 8; k++) begin
            ll = $urandom_range(8, 32);
            rl = $urandom_range(8, 32);
            lv = rand_val(ll);
            rv = rand_val(rl);
            sample_ready = 1'($urandom);
            add_frame(lv, ll, rv, rl);
            play(1'b0);
        end
        drain(8);
        check_eq("rand_err_count", 32'(err_seen), 32'(exp_err));

        // 6a: reset mid-right slot
        add_frame(rand_val(16), 32, rand_val(16), 32);
        add_frame(rand_val(16), 32, rand_val(16), 32);
        add_slot(1'b0, rand_val(16), 32);
        add_slot(1'b1, rand_val(16), 10);
        play(1'b1);
        check_eq("t6_pre_level", 32'(fifo_level), 32'h2);
        do_reset(1'b1);
        add_preamble(22);
        add_frame(16'h6006, 32, 16'h9009, 32);
        play(1'b0);
        check_eq("t6_level", 32'(fifo_level), 32'h1);
        check_eq("t6_left",  32'(sample_left), 32'h6006);

        // 6b: enable dropped mid-frame; queued pairs still drain
        add_slot(1'b0, rand_val(16), 10);
        play(1'b0);
        @(posedge clk); #1;
        en = 1'b0;
        locked = 1'b0;
        drain(4);
        check_eq("t6_drained", 32'(sample_valid), 32'h0);
        add_slot(1'b0, rand_val(16), 22);
        add_slot(1'b1, rand_val(16), 32);
        add_frame(16'h7777, 32, 16'h8888, 32);
        play(1'b0);
        check_eq("t6_dis_level", 32'(fifo_level), 32'h0);
        @(posedge clk); #1;
        en = 1'b1;
        add_preamble(32);
        add_frame(16'h4321, 32, 16'h8765, 32);
        play(1'b0);
        check_eq("t6_en_left",  32'(sample_left),  32'h4321);
        check_eq("t6_en_right", 32'(sample_right), 32'h8765);
        drain(4);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
